obi_axi_master: RTL and testbench

OBI_AXI_MASTER -- requirements
Module: obi_axi_master

---
 rtl/axi_master_pkg.sv | 16 +
 rtl/axi_bus.sv | 90 +++++++++
 rtl/obi_axi_master.sv | 152 +++++++++++++++
 tb/tb_obi_axi_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the OBI-to-AXI4 single-beat master.
package axi_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWriteResp,
    StRead,
    StReadResp
  } axi_master_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle with master and slave views.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/obi_axi_master.sv
// OBI slave port to AXI4 master bridge: single-beat, one transaction in flight.
module obi_axi_master
  import axi_master_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32, // only 32 is supported
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  AXI_BUS.Master      AXI_Master
);

  axi_master_state_e         state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [3:0]                be_q;
  logic [31:0]               wdata_q;
  logic                      aw_valid_q, w_valid_q, ar_valid_q, b_ready_q, r_ready_q;
  logic                      rvalid_q, err_q;
  logic [31:0]               rdata_q;

  assign data_gnt_o = data_req_i && (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_req_i) begin
            addr_q  <= AXI_ADDR_WIDTH'(data_addr_i);
            be_q    <= data_be_i;
            wdata_q <= data_wdata_i;
            if (data_we_i) begin
              state_q    <= StWrite;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= StRead;
              ar_valid_q <= 1'b1;
            end
          end
        end
        StWrite: begin
          // AW and W complete independently; leave once neither is still pending.
          aw_valid_q <= aw_valid_q && !AXI_Master.aw_ready;
          w_valid_q  <= w_valid_q && !AXI_Master.w_ready;
          if ((!aw_valid_q || AXI_Master.aw_ready) && (!w_valid_q || AXI_Master.w_ready)) begin
            state_q   <= StWriteResp;
            b_ready_q <= 1'b1;
          end
        end
        StWriteResp: begin
          if (AXI_Master.b_valid) begin
            state_q   <= StIdle;
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            err_q     <= AXI_Master.b_resp[1];
            rdata_q   <= '0;
          end
        end
        StRead: begin
          if (AXI_Master.ar_ready) begin
            state_q    <= StReadResp;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        StReadResp: begin
          if (AXI_Master.r_valid) begin
            state_q   <= StIdle;
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            // A beat without r_last means the slave answered with a burst we never asked for.
            err_q     <= AXI_Master.r_resp[1] || !AXI_Master.r_last;
            rdata_q   <= AXI_Master.r_data;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  assign AXI_Master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.aw_addr   = addr_q;
  assign AXI_Master.aw_len    = 8'd0;
  assign AXI_Master.aw_size   = AXI_SIZE_4B;
  assign AXI_Master.aw_burst  = AXI_BURST_INCR;
  assign AXI_Master.aw_lock   = 1'b0;
  assign AXI_Master.aw_cache  = 4'd0;
  assign AXI_Master.aw_prot   = 3'd0;
  assign AXI_Master.aw_qos    = 4'd0;
  assign AXI_Master.aw_region = 4'd0;
  assign AXI_Master.aw_atop   = 6'd0;
  assign AXI_Master.aw_user   = '0;
  assign AXI_Master.aw_valid  = aw_valid_q;

  assign AXI_Master.w_data    = wdata_q;
  assign AXI_Master.w_strb    = be_q;
  assign AXI_Master.w_last    = 1'b1;
  assign AXI_Master.w_user    = '0;
  assign AXI_Master.w_valid   = w_valid_q;

  assign AXI_Master.b_ready   = b_ready_q;

  assign AXI_Master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.ar_addr   = addr_q;
  assign AXI_Master.ar_len    = 8'd0;
  assign AXI_Master.ar_size   = AXI_SIZE_4B;
  assign AXI_Master.ar_burst  = AXI_BURST_INCR;
  assign AXI_Master.ar_lock   = 1'b0;
  assign AXI_Master.ar_cache  = 4'd0;
  assign AXI_Master.ar_prot   = 3'd0;
  assign AXI_Master.ar_qos    = 4'd0;
  assign AXI_Master.ar_region = 4'd0;
  assign AXI_Master.ar_user   = '0;
  assign AXI_Master.ar_valid  = ar_valid_q;

  assign AXI_Master.r_ready   = r_ready_q;

  logic unused_resp_fields;
  assign unused_resp_fields = ^{AXI_Master.b_id, AXI_Master.b_user,
                                AXI_Master.r_id, AXI_Master.r_user};

endmodule

// File: tb/tb_obi_axi_master.sv
// Scoreboard bench for obi_axi_master with a small configurable AXI slave model.
module tb_obi_axi_master;
  import axi_master_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  always #5 clk_i = ~clk_i;

  AXI_BUS #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)
  ) axi ();

  obi_axi_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10),
    .AXI_ID(5)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .AXI_Master   (axi)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Slave model configuration
  int          aw_lat = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_rresp = 2'b00;
  logic        cfg_rlast = 1'b1;
  logic        hold_r = 1'b0;

  logic [31:0] slv_mem [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  int          aw_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] waddr, wdat, rdat;
  logic [3:0]  wstrb;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_cnt <= 0;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      b_pend <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (axi.aw_valid && axi.aw_ready) begin
        aw_got <= 1'b1;
        waddr  <= axi.aw_addr;
        aw_cnt <= 0;
      end else if (axi.aw_valid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (axi.w_valid && axi.w_ready) begin
        w_got <= 1'b1;
        wdat  <= axi.w_data;
        wstrb <= axi.w_strb;
      end
      if (aw_got && w_got && !b_pend) begin
        slv_mem[waddr[9:2]] <= merge(slv_mem[waddr[9:2]], wdat, wstrb);
        b_pend <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (axi.b_valid && axi.b_ready) b_pend <= 1'b0;
      if (axi.ar_valid && axi.ar_ready) begin
        r_pend <= 1'b1;
        rdat   <= slv_mem[axi.ar_addr[9:2]];
      end
      if (axi.r_valid && axi.r_ready) r_pend <= 1'b0;
    end
  end

  assign axi.aw_ready = (aw_cnt >= aw_lat);
  assign axi.w_ready  = 1'b1;
  assign axi.b_valid  = b_pend;
  assign axi.b_resp   = cfg_bresp;
  assign axi.b_id     = '0;
  assign axi.b_user   = '0;
  assign axi.ar_ready = 1'b1;
  assign axi.r_valid  = r_pend && !hold_r;
  assign axi.r_data   = rdat;
  assign axi.r_resp   = cfg_rresp;
  assign axi.r_last   = cfg_rlast;
  assign axi.r_id     = '0;
  assign axi.r_user   = '0;

  // Monitor
  logic        hs_q = 1'b0;
  logic        b_rdy_prev = 1'b0;
  int          n_resp = 0;
  int          aw_hi = 0;
  int          w_hi = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  cur_be = '0;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hs_q <= 1'b0;
    else hs_q <= (axi.b_valid && axi.b_ready) || (axi.r_valid && axi.r_ready);
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (data_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check_eq("stray_rvalid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("rdata", data_rdata_o, e.rdata);
          check_eq("err", data_err_o, e.err);
        end
        n_resp <= n_resp + 1;
      end
      if (data_rvalid_o || hs_q) check_eq("rvalid_timing", data_rvalid_o, hs_q);
      if (data_gnt_o)
        check_eq("one_outstanding",
                 {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 64'd0);
      if (axi.aw_valid) begin
        aw_hi <= aw_hi + 1;
        check_eq("aw_fields", {axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.aw_id},
                 {cur_addr, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR, 16'd5});
      end
      if (axi.w_valid) begin
        w_hi <= w_hi + 1;
        check_eq("w_fields", {axi.w_data, axi.w_strb, axi.w_last}, {cur_wdata, cur_be, 1'b1});
      end
      if (axi.ar_valid)
        check_eq("ar_fields", {axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst, axi.ar_id},
                 {cur_addr, 8'd0, AXI_SIZE_4B, AXI_BURST_INCR, 16'd5});
      if (axi.b_ready && !b_rdy_prev) check_eq("b_after_aw_w", aw_got && w_got, 64'd1);
      b_rdy_prev <= axi.b_ready;
    end
  end

  // Called at a negedge; returns at the negedge after the grant edge.
  task automatic obi_issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input bit keep_req);
    exp_t e;
    int   n;
    data_req_i   = 1'b1;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wdata;
    if (we) begin
      ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, be);
      e = '{rdata: 32'h0, err: cfg_bresp[1]};
    end else begin
      e = '{rdata: ref_mem[addr[9:2]], err: cfg_rresp[1] | !cfg_rlast};
    end
    n = 0;
    #1;
    while (!data_gnt_o && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!data_gnt_o) begin
      check_eq("gnt_timeout", 64'd0, 64'd1);
      data_req_i = 1'b0;
      @(negedge clk_i);
      return;
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_be    = be;
    @(negedge clk_i);
    if (we) check_eq("aw_w_after_gnt", {axi.aw_valid, axi.w_valid}, 64'd3);
    else    check_eq("ar_after_gnt", axi.ar_valid, 64'd1);
    if (!keep_req) data_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    data_req_i = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("drain", exp_q.size(), 64'd0);
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, w0, r0, n;
    repeat (3) @(negedge clk_i);
    check_eq("reset_outs", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready,
                            axi.r_ready, data_rvalid_o, data_err_o, data_rdata_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Plain write then read-back
    obi_issue(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0);
    wait_idle();
    r0 = n_resp;
    obi_issue(1'b0, 32'h100, 4'hF, 32'h0, 1'b0);
    wait_idle();
    check_eq("one_rvalid_read", n_resp - r0, 64'd1);

    // AW accepted on its third valid cycle, W immediately
    aw_lat = 2;
    a0 = aw_hi;
    w0 = w_hi;
    obi_issue(1'b1, 32'h104, 4'hF, 32'h12345678, 1'b0);
    wait_idle();
    check_eq("aw_valid_cycles", aw_hi - a0, 64'd3);
    check_eq("w_valid_cycles", w_hi - w0, 64'd1);
    aw_lat = 0;

    // Error responses
    cfg_rresp = 2'b10;
    obi_issue(1'b0, 32'h100, 4'hF, 32'h0, 1'b0);
    wait_idle();
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    obi_issue(1'b1, 32'h108, 4'h5, 32'hA5A5A5A5, 1'b0);
    wait_idle();
    cfg_bresp = 2'b00;
    cfg_rlast = 1'b0;
    obi_issue(1'b0, 32'h104, 4'hF, 32'h0, 1'b0);
    wait_idle();
    cfg_rlast = 1'b1;

    // Back-to-back alternating traffic with the request held high
    r0 = n_resp;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ad;
      ad = 32'h200 + 32'(i / 2) * 4;
      obi_issue(~i[0], ad, (i == 2) ? 4'h3 : 4'hF, 32'hC0DE0000 + 32'(i * 32'h1111), i != 7);
    end
    wait_idle();
    check_eq("b2b_responses", n_resp - r0, 64'd8);

    // Reset while waiting for R
    hold_r = 1'b1;
    obi_issue(1'b0, 32'h100, 4'hF, 32'h0, 1'b0);
    n = 0;
    while (!axi.r_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check_eq("reach_read_resp", axi.r_ready, 64'd1);
    r0 = n_resp;
    rst_ni = 1'b0;
    #1;
    check_eq("reset_mid_read", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready,
                                axi.r_ready, data_rvalid_o, data_err_o, data_rdata_o}, 64'd0);
    exp_q.delete();
    hold_r = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    check_eq("no_rvalid_after_reset", n_resp - r0, 64'd0);
    obi_issue(1'b0, 32'h104, 4'hF, 32'h0, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
